// File: rtl/score_text_writer_pkg.sv
// Shared types, character codes, message table and the double-dabble step for score_text_writer.
// Optional feature macro: SCORE_LEADING_BLANK_EN (leading zero digits written as spaces).
package score_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONV     = 2'd1,
        ST_SCORE_WR = 2'd2,
        ST_MSG_WR   = 2'd3
    } state_t;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_ZERO    = 8'h30;
    localparam logic [3:0] MSG_LEN      = 4'd10;
    localparam logic [3:0] SCORE_DIGITS = 4'd5;

    // Row = msg_id, column = cell 0..9, left-aligned and space-padded.
    localparam logic [7:0] MSG_TABLE [4][10] = '{
        '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20},
        '{8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h21, 8'h20, 8'h20, 8'h20, 8'h20},
        '{8'h47, 8'h41, 8'h4D, 8'h45, 8'h20, 8'h4F, 8'h56, 8'h45, 8'h52, 8'h20},
        '{8'h59, 8'h4F, 8'h55, 8'h20, 8'h57, 8'h49, 8'h4E, 8'h20, 8'h20, 8'h20}
    };

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic bit_in);
        logic [19:0] adj;
        adj = bcd;
        for (int k = 0; k < 5; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) begin
                adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
            end else begin
                adj[k*4 +: 4] = bcd[k*4 +: 4];
            end
        end
        return {adj[18:0], bit_in};
    endfunction

endpackage

// File: rtl/score_text_writer_if.sv
// Request/write-port bundle of score_text_writer; master = game logic + RAM side, slave = writer.
interface score_text_writer_if;
    logic [15:0] score;
    logic        score_update;
    logic        msg_req;
    logic [1:0]  msg_id;
    logic [7:0]  wr_address;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;

    modport master (
        output score, score_update, msg_req, msg_id,
        input  wr_address, wr_data, wr_en, busy, done
    );

    modport slave (
        input  score, score_update, msg_req, msg_id,
        output wr_address, wr_data, wr_en, busy, done
    );
endinterface

// File: rtl/score_text_writer_bin2bcd_serial.sv
// Serial 16-bit binary to 5-digit BCD converter; the first shift happens on the start edge,
// so the result is valid (done pulse) 16 edges after start including the start edge.
module bin2bcd_serial
    import score_text_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [19:0] o_bcd
);

    logic [19:0] r_bcd;
    logic [15:0] r_sh;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    // Load-and-shift on start, then one shift per cycle until the remaining count runs out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcd  <= 20'd0;
            r_sh   <= 16'd0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bcd  <= dabble_step(20'd0, i_bin[15]);
                r_sh   <= {i_bin[14:0], 1'b0};
                r_cnt  <= 4'd15;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= dabble_step(r_bcd, r_sh[15]);
                r_sh  <= {r_sh[14:0], 1'b0};
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                end
            end else begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/score_text_writer.sv
// Text-RAM write controller: arbitrates score/message requests and emits one cell write per cycle.
// Optional feature macro: SCORE_LEADING_BLANK_EN (blank leading zeros of the score, LSD always shown).
module score_text_writer
    import score_text_pkg::*;
#(
    parameter logic [7:0] SCORE_BASE = 8'd6,
    parameter logic [7:0] MSG_BASE   = 8'd115
)(
    input  logic                Clk,
    input  logic                Reset_n,
    score_text_writer_if.slave  bus
);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [1:0]  r_job_id;
    logic        r_lead;
    logic        r_score_pend;
    logic [15:0] r_score_val;
    logic        r_msg_pend;
    logic [1:0]  r_msg_val;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_wr_en;
    logic        r_busy;
    logic        r_done;

    logic        w_msg_go;
    logic        w_score_go;
    logic        w_msg_accept;
    logic        w_score_accept;
    logic [1:0]  w_msg_sel;
    logic [15:0] w_score_sel;
    logic        w_conv_busy;
    logic        w_conv_done;
    logic [19:0] w_bcd;
    logic [2:0]  w_pos;
    logic [3:0]  w_digit;
    logic        w_lead_in;
    logic        w_lead_out;
    logic [7:0]  w_char;

    // Request bypass in IDLE: a same-cycle request is treated as if already pending.
    always_comb begin
        w_msg_go       = bus.msg_req | r_msg_pend;
        w_score_go     = (bus.score_update | r_score_pend) & ~w_conv_busy;
        w_msg_sel      = bus.msg_req ? bus.msg_id : r_msg_val;
        w_score_sel    = bus.score_update ? bus.score : r_score_val;
        if (r_state == ST_IDLE) begin
            w_msg_accept   = w_msg_go;
            w_score_accept = w_score_go & ~w_msg_go;
        end else begin
            w_msg_accept   = 1'b0;
            w_score_accept = 1'b0;
        end
    end

    bin2bcd_serial u_bin2bcd (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_start (w_score_accept),
        .i_bin   (w_score_sel),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // Pick the digit for the next score write (MSD first) and its font code.
    always_comb begin
        if (r_state == ST_SCORE_WR) begin
            w_pos     = 3'd4 - r_idx[2:0];
            w_lead_in = r_lead;
        end else begin
            w_pos     = 3'd4;
            w_lead_in = 1'b1;
        end
        case (w_pos)
            3'd0:    w_digit = w_bcd[3:0];
            3'd1:    w_digit = w_bcd[7:4];
            3'd2:    w_digit = w_bcd[11:8];
            3'd3:    w_digit = w_bcd[15:12];
            3'd4:    w_digit = w_bcd[19:16];
            default: w_digit = 4'd0;
        endcase
        w_lead_out = w_lead_in & (w_digit == 4'd0);
`ifdef SCORE_LEADING_BLANK_EN
        if (w_lead_out && (w_pos != 3'd0)) begin
            w_char = CHAR_SPACE;
        end else begin
            w_char = CHAR_ZERO + {4'd0, w_digit};
        end
`else
        w_char = CHAR_ZERO + {4'd0, w_digit};
`endif
    end

    // Main FSM with registered write port, busy and done.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_job_id     <= 2'd0;
            r_lead       <= 1'b0;
            r_score_pend <= 1'b0;
            r_score_val  <= 16'd0;
            r_msg_pend   <= 1'b0;
            r_msg_val    <= 2'd0;
            r_wr_addr    <= 8'd0;
            r_wr_data    <= 8'd0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            if (w_score_accept) begin
                r_score_pend <= 1'b0;
            end else if (bus.score_update) begin
                r_score_pend <= 1'b1;
                r_score_val  <= bus.score;
            end else begin
                r_score_pend <= r_score_pend;
            end

            if (w_msg_accept) begin
                r_msg_pend <= 1'b0;
            end else if (bus.msg_req) begin
                r_msg_pend <= 1'b1;
                r_msg_val  <= bus.msg_id;
            end else begin
                r_msg_pend <= r_msg_pend;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_msg_accept) begin
                        r_state   <= ST_MSG_WR;
                        r_job_id  <= w_msg_sel;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= MSG_BASE;
                        r_wr_data <= MSG_TABLE[w_msg_sel][0];
                        r_idx     <= 4'd1;
                        r_busy    <= 1'b1;
                    end else if (w_score_accept) begin
                        r_state <= ST_CONV;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_CONV: begin
                    if (w_conv_done) begin
                        r_state   <= ST_SCORE_WR;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= SCORE_BASE;
                        r_wr_data <= w_char;
                        r_lead    <= w_lead_out;
                        r_idx     <= 4'd1;
                    end else begin
                        r_state <= ST_CONV;
                    end
                end
                ST_SCORE_WR: begin
                    if (r_idx == SCORE_DIGITS) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= SCORE_BASE + {4'd0, r_idx};
                        r_wr_data <= w_char;
                        r_lead    <= w_lead_out;
                        r_idx     <= r_idx + 4'd1;
                    end
                end
                ST_MSG_WR: begin
                    if (r_idx == MSG_LEN) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= MSG_BASE + {4'd0, r_idx};
                        r_wr_data <= MSG_TABLE[r_job_id][r_idx];
                        r_idx     <= r_idx + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_address = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_en      = r_wr_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_score_text_writer.sv
// Directed self-checking bench for score_text_writer (expectations follow SCORE_LEADING_BLANK_EN).
module tb_score_text_writer;

    localparam logic [7:0] SB = 8'd6;
    localparam logic [7:0] MB = 8'd115;

    logic clk = 1'b0;
    logic rst_n;
    int   checks    = 0;
    int   failures  = 0;
    int   wr_count  = 0;
    int   saved_cnt = 0;

    score_text_writer_if bus();

    score_text_writer #(.SCORE_BASE(SB), .MSG_BASE(MB)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Count cells actually latched by the RAM.
    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accept edge (k=0) or later (kstart); exp holds 5 chars MSD first.
    task automatic check_score(input int kstart, input logic [39:0] exp);
        for (int k = kstart + 1; k <= 21; k++) begin
            tick;
            if (k >= 16 && k <= 20) begin
                chk("score_wr_en", {31'd0, bus.wr_en}, 32'd1);
                chk("score_addr", {24'd0, bus.wr_address}, 32'(SB) + 32'(k - 16));
                chk("score_data", {24'd0, bus.wr_data}, {24'd0, exp[39-8*(k-16) -: 8]});
                chk("score_busy_wr", {31'd0, bus.busy}, 32'd1);
            end else if (k < 16) begin
                chk("score_conv_wr_en", {31'd0, bus.wr_en}, 32'd0);
                chk("score_conv_done", {31'd0, bus.done}, 32'd0);
                chk("score_conv_busy", {31'd0, bus.busy}, 32'd1);
            end else begin
                chk("score_done", {31'd0, bus.done}, 32'd1);
                chk("score_busy_end", {31'd0, bus.busy}, 32'd0);
                chk("score_wr_en_end", {31'd0, bus.wr_en}, 32'd0);
            end
        end
    endtask

    // Called right after the accept edge; exp holds 10 chars, cell 0 first.
    task automatic check_msg(input logic [79:0] exp);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick;
            if (k < 10) begin
                chk("msg_wr_en", {31'd0, bus.wr_en}, 32'd1);
                chk("msg_addr", {24'd0, bus.wr_address}, 32'(MB) + 32'(k));
                chk("msg_data", {24'd0, bus.wr_data}, {24'd0, exp[79-8*k -: 8]});
                chk("msg_done_early", {31'd0, bus.done}, 32'd0);
            end else begin
                chk("msg_done", {31'd0, bus.done}, 32'd1);
                chk("msg_busy_end", {31'd0, bus.busy}, 32'd0);
                chk("msg_wr_en_end", {31'd0, bus.wr_en}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [39:0] exp_7;
        logic [39:0] exp_1;
        logic [39:0] exp_200;
`ifdef SCORE_LEADING_BLANK_EN
        exp_7   = "    7";
        exp_1   = "    1";
        exp_200 = "  200";
`else
        exp_7   = "00007";
        exp_1   = "00001";
        exp_200 = "00200";
`endif
        rst_n            = 1'b0;
        bus.score        = 16'd0;
        bus.score_update = 1'b0;
        bus.msg_req      = 1'b0;
        bus.msg_id       = 2'd0;
        tick;
        tick;
        chk("rst_wr_address", {24'd0, bus.wr_address}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        tick;
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // Score 12345
        bus.score        = 16'd12345;
        bus.score_update = 1'b1;
        tick;
        bus.score_update = 1'b0;
        chk("s12345_busy", {31'd0, bus.busy}, 32'd1);
        chk("s12345_wr_en0", {31'd0, bus.wr_en}, 32'd0);
        check_score(0, "12345");
        tick;

        // Score 7, padding depends on the leading-blank option
        bus.score        = 16'd7;
        bus.score_update = 1'b1;
        tick;
        bus.score_update = 1'b0;
        check_score(0, exp_7);
        tick;

        // Simultaneous message and score: message wins, score follows after one IDLE cycle
        bus.msg_req      = 1'b1;
        bus.msg_id       = 2'd2;
        bus.score        = 16'd65535;
        bus.score_update = 1'b1;
        tick;
        bus.msg_req      = 1'b0;
        bus.score_update = 1'b0;
        check_msg("GAME OVER ");
        tick;
        chk("s65535_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("s65535_accept_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check_score(0, "65535");
        tick;

        // Requests during a score job collapse to the latest value
        bus.score        = 16'd1;
        bus.score_update = 1'b1;
        tick;
        bus.score        = 16'd100;
        tick;
        bus.score        = 16'd200;
        tick;
        bus.score_update = 1'b0;
        check_score(2, exp_1);
        tick;
        chk("s200_accept_busy", {31'd0, bus.busy}, 32'd1);
        check_score(0, exp_200);
        saved_cnt = wr_count;
        repeat (25) tick;
        chk("s200_single_job_writes", 32'(wr_count), 32'(saved_cnt));
        chk("s200_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Reset during the third message write discards the job and a pending score
        bus.msg_req = 1'b1;
        bus.msg_id  = 2'd1;
        tick;
        bus.msg_req      = 1'b0;
        bus.score        = 16'd9;
        bus.score_update = 1'b1;
        tick;
        bus.score_update = 1'b0;
        tick;
        chk("rstmid_third_wr_en", {31'd0, bus.wr_en}, 32'd1);
        chk("rstmid_third_data", {24'd0, bus.wr_data}, 32'h41);
        chk("rstmid_third_addr", {24'd0, bus.wr_address}, 32'(MB) + 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rstmid_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstmid_async_addr", {24'd0, bus.wr_address}, 32'd0);
        saved_cnt = wr_count;
        #3;
        rst_n = 1'b1;
        repeat (30) tick;
        chk("rstmid_no_writes", 32'(wr_count), 32'(saved_cnt));
        chk("rstmid_busy_after", {31'd0, bus.busy}, 32'd0);

        // Blank message
        bus.msg_req = 1'b1;
        bus.msg_id  = 2'd0;
        tick;
        bus.msg_req = 1'b0;
        check_msg("          ");
        tick;
        chk("blank_idle_after", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
